// File: rtl/apb_uart_arbiter_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
// Request widths track the default DATA_WIDTH/ADDR_WIDTH of the top.
package apb_uart_arb_pkg;

   localparam int NUM_REQ    = 2;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   typedef struct packed {
      logic                  write;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
   } apb_req_t;

endpackage

// File: rtl/apb_uart_arbiter_rr.sv
// Two-way round-robin grant; a lone requester always wins, a tie goes to
// the requester that was not granted last.
module apb_rr_arbiter
   import apb_uart_arb_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic               i_accept,
   output logic [NUM_REQ-1:0] o_gnt
);

   logic r_last_gnt;

   always_comb begin
      o_gnt = i_valid;
      if (i_valid == 2'b11) begin
         o_gnt = r_last_gnt ? 2'b01 : 2'b10;
      end
   end

   // Reset to 1 so the first tie after reset goes to requester 0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_gnt <= 1'b1;
      end else if (i_accept) begin
         r_last_gnt <= o_gnt[1];
      end
   end

endmodule

// File: rtl/apb_uart_arbiter.sv
// APB master shared by two requesters: round-robin accept, SETUP/ACCESS
// sequencing with wait states. Optional ACCESS watchdog: APB_ARB_TIMEOUT_EN.
module apb_uart_arbiter
   import apb_uart_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                PCLK,
   input  logic                                PRESET,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0]                  req_write,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   output logic [DATA_WIDTH-1:0]               rsp_rdata,
   output logic                                rsp_err,
   output logic                                PSELx,
   output logic                                PENABLE,
   output logic                                PWRITE,
   output logic [ADDR_WIDTH-1:0]               PADDR,
   output logic [DATA_WIDTH-1:0]               PWDATA,
   input  logic [DATA_WIDTH-1:0]               PRDATA,
   input  logic                                PREADY,
   input  logic                                PSLVERR
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_uart_arbiter: TIMEOUT_CYCLES must be >= 1");
   end

   state_t                r_state;
   state_t                w_next;
   logic [NUM_REQ-1:0]    w_gnt;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_timeout;
   logic                  r_gnt_idx;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [NUM_REQ-1:0]    r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   assign w_accept  = (r_state == IDLE) && (|req_valid);
   assign w_done    = (r_state == ACCESS) && PREADY;
   assign req_ready = (r_state == IDLE) ? w_gnt : '0;

   apb_rr_arbiter u_rr (
      .i_clk    (PCLK),
      .i_rst    (PRESET),
      .i_valid  (req_valid),
      .i_accept (w_accept),
      .o_gnt    (w_gnt)
   );

`ifdef APB_ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;

   // Abort on the ACCESS cycle whose stall would bring the count to the limit
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_to_cnt <= '0;
      end else if (r_state == SETUP) begin
         r_to_cnt <= '0;
      end else if ((r_state == ACCESS) && !PREADY) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == ACCESS) && !PREADY && (r_to_cnt == TO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = SETUP;
         end
         SETUP: begin
            PSELx  = 1'b1;
            w_next = ACCESS;
         end
         ACCESS: begin
            PSELx   = 1'b1;
            PENABLE = 1'b1;
            if (w_done || w_timeout) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Request fields double as the APB drive, so they hold between transfers
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_gnt_idx   <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         if (w_accept) begin
            r_gnt_idx <= w_gnt[1];
            r_write   <= req_write[w_gnt[1]];
            r_addr    <= req_addr[w_gnt[1]];
            r_wdata   <= req_wdata[w_gnt[1]];
         end
         if (w_done) begin
            r_rsp_valid[r_gnt_idx] <= 1'b1;
            r_rsp_rdata            <= r_write ? '0 : PRDATA;
            r_rsp_err              <= PSLVERR;
         end else if (w_timeout) begin
            r_rsp_valid[r_gnt_idx] <= 1'b1;
            r_rsp_rdata            <= '0;
            r_rsp_err              <= 1'b1;
         end
      end
   end

   assign PWRITE    = r_write;
   assign PADDR     = r_addr;
   assign PWDATA    = r_wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Bench for apb_uart_arbiter: vector table + scoreboard of expected responses,
// plus hand sequences for round-robin, mid-transfer reset and the watchdog.
module tb_apb_uart_arbiter;
   import apb_uart_arb_pkg::*;

   localparam int TO_CYC = 8;

   logic            PCLK = 1'b0;
   logic            PRESET = 1'b1;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_write = '0;
   logic [1:0][31:0] req_addr = '0;
   logic [1:0][31:0] req_wdata = '0;
   logic [1:0]      req_ready;
   logic [1:0]      rsp_valid;
   logic [31:0]     rsp_rdata;
   logic            rsp_err;
   logic            PSELx, PENABLE, PWRITE;
   logic [31:0]     PADDR, PWDATA;
   logic [31:0]     PRDATA = '0;
   logic            PREADY = 1'b0;
   logic            PSLVERR = 1'b0;

   apb_uart_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      int          id;
      apb_req_t    req;
      logic [31:0] prdata;
      int          waits;
      logic        slverr;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   rsp_t sb_q[$];
   int   gnt_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave model: PREADY rises after s_waits stalled ACCESS cycles
   int          s_waits = 0;
   int          s_cnt   = 0;
   logic [31:0] s_rdata = '0;
   logic        s_err   = 1'b0;

   always @(posedge PCLK) begin
      #1;
      if (PSELx && PENABLE) begin
         PREADY  = (s_cnt >= s_waits);
         PRDATA  = s_rdata;
         PSLVERR = s_err;
         s_cnt++;
      end else begin
         PREADY  = 1'b0;
         PRDATA  = '0;
         PSLVERR = 1'b0;
         s_cnt   = 0;
      end
   end

   // Monitor: grant log, one-hot ready, scoreboard compare on each response
   always @(negedge PCLK) begin
      rsp_t e;
      if (req_ready != 2'b00) begin
         check("ready_onehot", 64'($onehot(req_ready)), 64'(1));
         check("ready_needs_valid", 64'(req_ready & ~req_valid), 64'(0));
      end
      if ((req_valid & req_ready) != 2'b00) gnt_q.push_back(req_ready[1] ? 1 : 0);
      if (rsp_valid != 2'b00) begin
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'(0));
         end else begin
            e = sb_q.pop_front();
            check("rsp_id", 64'(rsp_valid), 64'(2'b01 << e.id));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
   end

   task automatic drain(input string name);
      int c = 0;
      while (sb_q.size() != 0 && c < 100) begin
         @(posedge PCLK);
         c++;
      end
      check(name, 64'(sb_q.size()), 64'(0));
   endtask

   task automatic xfer(input vec_t v);
      int cyc;
      s_waits = v.waits;
      s_rdata = v.prdata;
      s_err   = v.slverr;
      sb_q.push_back('{v.id, v.exp_rdata, v.exp_err});
      @(posedge PCLK); #1;
      req_valid[v.id] = 1'b1;
      req_write[v.id] = v.req.write;
      req_addr[v.id]  = v.req.addr;
      req_wdata[v.id] = v.req.wdata;
      cyc = 0;
      do begin
         @(negedge PCLK);
         cyc++;
      end while (!req_ready[v.id] && cyc < 20);
      check("handshake", 64'(req_ready[v.id]), 64'(1));
      @(posedge PCLK); #1;
      req_valid[v.id] = 1'b0;
      @(negedge PCLK);
      check("setup_sel_en", 64'({PSELx, PENABLE}), 64'(2'b10));
      check("setup_pwrite", 64'(PWRITE), 64'(v.req.write));
      check("setup_paddr", 64'(PADDR), 64'(v.req.addr));
      check("setup_pwdata", 64'(PWDATA), 64'(v.req.wdata));
      cyc = 0;
      @(negedge PCLK);
      while (PSELx && cyc < 100) begin
         check("access_en", 64'(PENABLE), 64'(1));
         check("access_paddr", 64'(PADDR), 64'(v.req.addr));
         check("access_pwdata", 64'(PWDATA), 64'(v.req.wdata));
         cyc++;
         @(negedge PCLK);
      end
      check("access_len", 64'(cyc), 64'(v.waits + 1));
      #1;
      check("rsp_seen", 64'(sb_q.size()), 64'(0));
   endtask

   vec_t vecs[6];

   initial begin
      int c;
      vecs[0] = '{0, '{1'b1, 32'h0000_0004, 32'h0000_00A5}, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0};
      vecs[1] = '{1, '{1'b0, 32'h0000_0008, 32'h0},         32'h1234_5678, 3, 1'b0, 32'h1234_5678, 1'b0};
      vecs[2] = '{0, '{1'b0, 32'h0000_0010, 32'h0},         32'hCAFE_F00D, 0, 1'b1, 32'hCAFE_F00D, 1'b1};
      vecs[3] = '{1, '{1'b1, 32'h0000_0014, 32'h0000_55AA}, 32'h8888_8888, 1, 1'b0, 32'h0, 1'b0};
      vecs[4] = '{1, '{1'b1, 32'h0000_0018, 32'hFFFF_0001}, 32'h7777_7777, 2, 1'b1, 32'h0, 1'b1};
      vecs[5] = '{0, '{1'b0, 32'hFFFF_FFFC, 32'h0},         32'h0BAD_CAFE, 5, 1'b0, 32'h0BAD_CAFE, 1'b0};

      // Reset state
      @(posedge PCLK);
      @(negedge PCLK);
      check("rst_apb", 64'({PSELx, PENABLE, PWRITE}), 64'(0));
      check("rst_paddr", 64'(PADDR), 64'(0));
      check("rst_pwdata", 64'(PWDATA), 64'(0));
      check("rst_rsp", 64'({rsp_valid, rsp_err}), 64'(0));
      check("rst_rdata", 64'(rsp_rdata), 64'(0));
      check("rst_ready", 64'(req_ready), 64'(0));
      @(posedge PCLK); #1;
      PRESET = 1'b0;

      // Both requesters valid continuously: grant order 0,1,0,1
      s_waits = 0; s_err = 1'b0; s_rdata = 32'h0000_0077;
      sb_q.push_back('{0, 32'h77, 1'b0});
      sb_q.push_back('{1, 32'h0,  1'b0});
      sb_q.push_back('{0, 32'h77, 1'b0});
      sb_q.push_back('{1, 32'h0,  1'b0});
      gnt_q.delete();
      @(posedge PCLK); #1;
      req_write = 2'b10;
      req_addr[0] = 32'h20; req_addr[1] = 32'h24;
      req_wdata[0] = 32'h0; req_wdata[1] = 32'h1111_2222;
      req_valid = 2'b11;
      c = 0;
      do begin
         @(posedge PCLK);
         c++;
      end while (gnt_q.size() < 4 && c < 40);
      #1;
      req_valid = 2'b00;
      check("rr_count", 64'(gnt_q.size()), 64'(4));
      for (int i = 0; i < 4 && i < gnt_q.size(); i++)
         check("rr_order", 64'(gnt_q[i]), 64'(i % 2));
      drain("rr_drain");

      // Table-driven single transfers
      for (int i = 0; i < 6; i++) xfer(vecs[i]);

      // Reset during ACCESS: no response, outputs cleared, next tie grants 0
      s_waits = 5; s_rdata = 32'h5555_0000; s_err = 1'b0;
      @(posedge PCLK); #1;
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'hABCD;
      c = 0;
      do begin
         @(negedge PCLK);
         c++;
      end while (!req_ready[0] && c < 20);
      @(posedge PCLK); #1;
      req_valid = 2'b00;
      @(negedge PCLK);
      @(negedge PCLK);
      check("prerst_access", 64'({PSELx, PENABLE}), 64'(2'b11));
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      @(negedge PCLK);
      check("midrst_apb", 64'({PSELx, PENABLE, PWRITE}), 64'(0));
      check("midrst_paddr", 64'(PADDR), 64'(0));
      check("midrst_pwdata", 64'(PWDATA), 64'(0));
      check("midrst_rsp", 64'({rsp_valid, rsp_err}), 64'(0));
      s_waits = 0; s_rdata = 32'h0000_0099;
      sb_q.push_back('{0, 32'h99, 1'b0});
      sb_q.push_back('{1, 32'h99, 1'b0});
      gnt_q.delete();
      @(posedge PCLK); #1;
      req_write = 2'b00;
      req_valid = 2'b11;
      c = 0;
      do begin
         @(posedge PCLK);
         c++;
      end while (gnt_q.size() < 2 && c < 40);
      #1;
      req_valid = 2'b00;
      check("postrst_count", 64'(gnt_q.size()), 64'(2));
      if (gnt_q.size() > 0) check("postrst_first", 64'(gnt_q[0]), 64'(0));
      drain("postrst_drain");

`ifdef APB_ARB_TIMEOUT_EN
      // Watchdog: PREADY never rises
      s_waits = 1000; s_rdata = 32'hBAD0_BAD0; s_err = 1'b0;
      sb_q.push_back('{1, 32'h0, 1'b1});
      @(posedge PCLK); #1;
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h60;
      c = 0;
      do begin
         @(negedge PCLK);
         c++;
      end while (!req_ready[1] && c < 20);
      @(posedge PCLK); #1;
      req_valid = 2'b00;
      @(negedge PCLK);
      c = 0;
      @(negedge PCLK);
      while (PSELx && c < 50) begin
         c++;
         @(negedge PCLK);
      end
      check("to_access_len", 64'(c), 64'(TO_CYC));
      check("to_apb_off", 64'({PSELx, PENABLE}), 64'(0));
      #1;
      check("to_rsp_seen", 64'(sb_q.size()), 64'(0));
      s_waits = 0; s_rdata = 32'h0000_00C3;
      sb_q.push_back('{0, 32'hC3, 1'b0});
      @(posedge PCLK); #1;
      req_valid[0] = 1'b1; req_write[0] = 1'b0;
      @(negedge PCLK);
      check("to_idle_ready", 64'(req_ready), 64'(2'b01));
      @(posedge PCLK); #1;
      req_valid = 2'b00;
      drain("to_drain");
`endif

      repeat (3) @(posedge PCLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_uart_arbiter.md
# apb_uart_arbiter

Two-requester APB master arbiter and transfer sequencer that shares the single APB slave port of `apb_uart_top` between two agents, for example a configuration engine and a data mover. It accepts one request at a time through a valid/ready handshake and grants requesters round-robin. It runs the APB SETUP/ACCESS protocol, including PREADY wait states, and returns read data and error status to the granted requester. It sits between the requesters and the UART's `PSELx/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR` pins.

## Interface
- `DATA_WIDTH`, 32: APB data width.
- `ADDR_WIDTH`, 32: APB address width.
- `TIMEOUT_CYCLES`, 64: ACCESS-phase watchdog limit; used only with the timeout macro; must be ≥ 1.

- `PCLK`  in  1  single clock; all logic on its rising edge.
- `PRESET`  in  1  reset, synchronous, active-high.
- `req_valid`  in  [1:0]  per-requester request valid.
- `req_write`  in  [1:0]  1 = write, 0 = read.
- `req_addr`  in  [1:0][ADDR_WIDTH-1:0]  request address.
- `req_wdata`  in  [1:0][DATA_WIDTH-1:0]  write data.
- `req_ready`  out  [1:0]  request accepted; at most one bit high.
- `rsp_valid`  out  [1:0]  one-cycle response pulse to the granted requester.
- `rsp_rdata`  out  DATA_WIDTH  read data, shared; valid with `rsp_valid`.
- `rsp_err`  out  1  PSLVERR (or timeout) for this response.
- `PSELx`, `PENABLE`, `PWRITE`  out  1  APB controls.
- `PADDR`  out  ADDR_WIDTH  APB address.
- `PWDATA`  out  DATA_WIDTH  APB write data.
- `PRDATA`  in  DATA_WIDTH  APB read data.
- `PREADY`, `PSLVERR`  in  1  APB completion and error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any `req_valid` bit is high, the arbiter picks grant `g`. `req_ready[g]` is driven combinationally high in the same cycle.
  - On that handshake it registers write, address and wdata, stores `g`, and moves to SETUP.
- **Round-robin**
  - Pointer `last_gnt` resets to 1.
  - When both requesters are valid, grant goes to `~last_gnt`. When only one is valid, it is granted.
  - `last_gnt` is updated to `g` on each accept.
- **SETUP**: `PSELx`=1, `PENABLE`=0, APB address/data/write driven from registers. Always exactly one cycle, then ACCESS.
- **ACCESS**: `PSELx`=1, `PENABLE`=1. Hold while `PREADY`=0.
  - On `PREADY`=1, register `PRDATA` (reads only; writes return 0) and `PSLVERR`, then go to IDLE.
  - In the next cycle, `rsp_valid[g]`=1 for one cycle.
- APB address, data and write outputs stay stable from SETUP through the end of ACCESS. Outside a transfer they hold their last values.
- Requesters must hold request fields stable while valid and not ready. A requester that drops `req_valid` before it is granted is simply not granted.
- A requester's valid and next request may be asserted in the same cycle as its `rsp_valid`.

## Timing
- Cycle 0: IDLE with handshake. Cycle 1: SETUP. Cycle 2: ACCESS with `PREADY`=1. Cycle 3: `rsp_valid`, and IDLE may accept a new request.
- Minimum throughput: one transfer per 3 cycles. Each PREADY-low cycle adds one cycle.
- Reset values: `PSELx`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `rsp_valid`, `rsp_rdata`, `rsp_err` are all 0; `req_ready` is 0; state is IDLE; `last_gnt`=1.
- `PRESET` asserted mid-transfer: the transfer is dropped with no response, and the next cycle is IDLE with all outputs at reset values.
- Simultaneous requests after reset: requester 0 first, then 1, then 0, and so on.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `PREADY`=0.
  - When the count reaches `TIMEOUT_CYCLES`, the transfer aborts: `PSELx`/`PENABLE` go to 0 next cycle and the state goes to IDLE.
  - The requester receives `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0.
- Not defined: no counter is built; ACCESS waits for `PREADY` indefinitely and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `apb_uart_arb_pkg` holds:
  - the `NUM_REQ`=2 constant;
  - the state enum typedef (IDLE/SETUP/ACCESS);
  - the request struct typedef (write, addr, wdata) parameterised via package localparams matching the defaults.
- Sub-module `apb_rr_arbiter`: 2-way round-robin grant logic with `last_gnt` register. Inputs: valid vector and accept strobe. Output: one-hot grant.

## Test plan
- Single write, requester 0, addr 0x0000_0004, data 0xA5, `PREADY` tied 1:
  - `PSELx` high cycles 1–2, `PENABLE` cycle 2, `PWDATA`=0xA5;
  - `rsp_valid[0]` in cycle 3 with `rsp_err`=0.
- Read with 3 wait states, `PRDATA`=0x1234_5678: ACCESS lasts 4 cycles, then `rsp_valid[1]` with `rsp_rdata`=0x1234_5678.
- Both requesters valid continuously, 4 transfers: grant order 0,1,0,1, never two `req_ready` bits together.
- `PSLVERR`=1 with `PREADY`: `rsp_err`=1 on that response only; the next transfer reports `rsp_err`=0.
- `PRESET` pulsed during ACCESS: no `rsp_valid`, all APB outputs 0 the next cycle, and the next simultaneous request grants requester 0.
- With `APB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `PREADY` held 0:
  - abort after 8 ACCESS cycles;
  - `rsp_err`=1, `rsp_rdata`=0, FSM back in IDLE.
